z80_bus_cycle_ctrl: RTL
=======================

Name: z80_bus_cycle_ctrl

Overview:
- Sequences external Z80 machine cycles (M-cycles) for the z80 top level.
- On a single-cycle `start` request from control_logic, runs one of five M-cycle types. For each it drives the address/data buses and the active-low strobes T-state by T-state. It honours WAIT_L, latches read data, and returns `done`.
- Owns the 7-bit memory-refresh counter R and drives the refresh address during opcode-fetch T3/T4.

Parameters:
- IO_AUTO_WAIT, 1: number of automatic wait states inserted in I/O cycles after T2 (0..3).
- WAIT_TIMEOUT, 255: TW count before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only while ready=1.
- cyc_type  in  3  0=OPFETCH, 1=MEM_RD, 2=MEM_WR, 3=IO_RD, 4=IO_WR; 5-7 reserved.
- addr_in  in  16  cycle address; captured with start.
- wdata  in  8  write data; captured with start.
- i_reg  in  8  I register, for the refresh address high byte.
- r_wr  in  1  load R from r_wdata (LD R,A).
- r_wdata  in  8  R load value.
- data_in  in  8  external data bus.
- WAIT_L  in  1  memory/IO wait request.
- ready  out  1  controller can accept start this cycle.
- done  out  1  one-cycle pulse in the final T-state.
- rdata  out  8  latched read data; holds until the next read.
- r_reg  out  8  current R.
- addr_out  out  16  address bus drive.
- data_out  out  8  write data bus drive.
- M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L  out  1 each  bus strobes.
- err  out  1  wait-timeout abort flag (optional feature).

Behaviour:
- States: IDLE, T1, T2, TA (automatic I/O wait), TW, T3, T4.
- All outputs are Moore-decoded from registered state and captured request fields. Strobes are glitch-free.
- Reset: state=IDLE; all strobes=1; ready=1; done=0; rdata=0; addr_out=0; data_out=0; R=0; err=0.
- Reset asserted mid-cycle aborts immediately to the reset values. No done is produced.
- Accept rule: start && ready captures cyc_type/addr_in/wdata and enters T1 next cycle.
  - ready=1 in IDLE and in the final T-state, so back-to-back cycles run with no idle gap.
  - Reserved cyc_type is ignored and the controller stays in IDLE.
- Transitions:
  - T1→T2.
  - T2→TA for IO types when IO_AUTO_WAIT>0 (TA repeats IO_AUTO_WAIT times). Otherwise T2→TW if WAIT_L==0, else T2→T3.
  - TA (last)→TW if WAIT_L==0, else TA→T3.
  - TW→TW while WAIT_L==0, else TW→T3.
  - T3→T4 for OPFETCH. T3 is final for all other types.
  - T4 is final for OPFETCH.
  - From the final state: go to T1 if start accepted, else IDLE.
- WAIT_L is sampled on the rising edge ending T2, the last TA, and each TW.
- Strobes and buses per type (low = asserted):
  - OPFETCH:
    - T1, T2, TW: M1_L=0, MREQ_L=0, RD_L=0, addr_out=addr.
    - rdata latched from data_in on the edge leaving T2/TW into T3.
    - T3, T4: M1_L=1, RD_L=1, MREQ_L=0, RFSH_L=0, addr_out={i_reg, R}.
  - MEM_RD: T1..T3: MREQ_L=0, RD_L=0. rdata latched on the edge ending T3.
  - MEM_WR:
    - T1..T3: MREQ_L=0.
    - T2, TW, T3: WR_L=0.
    - data_out=wdata from T1 through T3.
  - IO_RD/IO_WR: IORQ_L and RD_L/WR_L asserted in T2, TA, TW and T3. rdata latched on the edge ending T3.
  - In IDLE, addr_out holds its last value and data_out holds its last value.
- Minimum lengths: OPFETCH 4, MEM 3, IO 3+IO_AUTO_WAIT clocks.
- R counter:
  - On the edge leaving T4, R[6:0] increments mod 128; R[7] is preserved (0x7F→0x00, 0xFF→0x80).
  - r_wr loads R and has priority over the increment in the same cycle.

Optional Feature:
- Macro Z80_BUS_WAIT_TIMEOUT_EN.
- When defined:
  - A TW counter counts consecutive TW states.
  - Reaching WAIT_TIMEOUT forces T3 next cycle with err=1 sticky until reset; done still pulses.
  - OPFETCH continues normally into T4.
- When not defined: err is tied 0 and TW may last indefinitely.

Test Plan:
- After reset, OPFETCH at addr 0x1234 with data_in=0x3E, WAIT_L=1, i_reg=0x00:
  - M1_L low 2 clocks; RFSH_L low 2 clocks with addr_out=0x0000.
  - rdata=0x3E; done in the 4th clock; R becomes 0x01.
- MEM_WR addr 0x8000, wdata 0xA5, WAIT_L low for 2 samples:
  - WR_L low for 4 clocks; total 5 clocks; data_out=0xA5 throughout.
- IO_RD port 0x00FE, IO_AUTO_WAIT=1, data_in=0x5A:
  - IORQ_L and RD_L low T2..T3 (3 clocks); total 4 clocks; rdata=0x5A.
- Back-to-back: start asserted in the done cycle of MEM_RD:
  - Next clock is T1 of the new cycle; ready stays 1 only in final states.
- R=0x7F then OPFETCH → R=0x00. Load R=0xFF via r_wr, then OPFETCH → R=0x80. Assert r_wr during T4 → the loaded value wins.
- Reset asserted during a TW of IO_WR:
  - All strobes 1 and ready=1 the same cycle; no done.
  - With Z80_BUS_WAIT_TIMEOUT_EN and WAIT_TIMEOUT=4, WAIT_L held low → err=1 after 4 TW; done pulses.

Source files
------------

// File: rtl/z80_bus_cycle_ctrl_if.sv
// z80_bus_cycle_ctrl_if: request, refresh and external bus signals of
// the Z80 M-cycle sequencer; master = requester side, slave = sequencer.
interface z80_bus_cycle_ctrl_if;
  logic        start;
  logic [2:0]  cyc_type;
  logic [15:0] addr_in;
  logic [7:0]  wdata;
  logic [7:0]  i_reg;
  logic        r_wr;
  logic [7:0]  r_wdata;
  logic [7:0]  data_in;
  logic        WAIT_L;
  logic        ready;
  logic        done;
  logic [7:0]  rdata;
  logic [7:0]  r_reg;
  logic [15:0] addr_out;
  logic [7:0]  data_out;
  logic        M1_L;
  logic        MREQ_L;
  logic        IORQ_L;
  logic        RD_L;
  logic        WR_L;
  logic        RFSH_L;
  logic        err;

  modport master (
    output start, cyc_type, addr_in, wdata, i_reg,
    output r_wr, r_wdata, data_in, WAIT_L,
    input  ready, done, rdata, r_reg, addr_out, data_out,
    input  M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, err
  );

  modport slave (
    input  start, cyc_type, addr_in, wdata, i_reg,
    input  r_wr, r_wdata, data_in, WAIT_L,
    output ready, done, rdata, r_reg, addr_out, data_out,
    output M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, err
  );
endinterface

// File: rtl/z80_bus_cycle_ctrl.sv
// z80_bus_cycle_ctrl: Z80 M-cycle sequencer with the R refresh counter.
// Define Z80_BUS_WAIT_TIMEOUT_EN to abort over-long TW runs (sets err).
module z80_bus_cycle_ctrl #(
  parameter int IO_AUTO_WAIT = 1,
  parameter int WAIT_TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst,
  z80_bus_cycle_ctrl_if.slave bus
);
  localparam logic [2:0] C_OPF = 3'd0;
  localparam logic [2:0] C_MRD = 3'd1;
  localparam logic [2:0] C_MWR = 3'd2;
  localparam logic [2:0] C_IRD = 3'd3;
  localparam logic [2:0] C_IWR = 3'd4;
  localparam logic [1:0] TA_LAST = 2'(IO_AUTO_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, T1, T2, TA, TW, T3, T4
  } state_t;

  state_t      st, nxt;
  logic [2:0]  typ, nxt_typ;
  logic [15:0] cap_addr, nxt_addr;
  logic [7:0]  cap_wd, nxt_wd;
  logic [1:0]  ta_cnt;
  logic [7:0]  r_q, r_nxt;
  logic        accept, is_io, to_hit, busy, fin_n;
  logic        is_op, is_mrd, is_mwr, is_ird, is_iwr;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] a_n;
  logic [7:0]  d_n;

  logic        ready_q, done_q;
  logic        m1_q, mreq_q, iorq_q, rd_q, wr_q, rfsh_q;
  logic [15:0] addr_q;
  logic [7:0]  dout_q, rdata_q;

  assign is_io  = (typ == C_IRD) || (typ == C_IWR);
  assign accept = bus.start && ready_q && (bus.cyc_type <= C_IWR);

`ifdef Z80_BUS_WAIT_TIMEOUT_EN
  localparam int TW_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TW_W-1:0] TO_LAST = TW_W'(WAIT_TIMEOUT - 1);

  logic [TW_W-1:0] tw_cnt;
  logic            err_q;

  assign to_hit = (st == TW) && !bus.WAIT_L && (tw_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      tw_cnt <= (st == TW) ? tw_cnt + 1'b1 : '0;
      if (to_hit) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign to_hit  = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    nxt      = st;
    nxt_typ  = typ;
    nxt_addr = cap_addr;
    nxt_wd   = cap_wd;
    unique case (st)
      IDLE: if (accept) nxt = T1;
      T1:   nxt = T2;
      T2: begin
        if (is_io && (IO_AUTO_WAIT > 0)) nxt = TA;
        else nxt = bus.WAIT_L ? T3 : TW;
      end
      TA: if (ta_cnt == TA_LAST) nxt = bus.WAIT_L ? T3 : TW;
      TW: if (bus.WAIT_L || to_hit) nxt = T3;
      T3: begin
        if (typ == C_OPF) nxt = T4;
        else nxt = accept ? T1 : IDLE;
      end
      T4:   nxt = accept ? T1 : IDLE;
      default: nxt = IDLE;
    endcase
    if (accept) begin
      nxt_typ  = bus.cyc_type;
      nxt_addr = bus.addr_in;
      nxt_wd   = bus.wdata;
    end
  end

  // R only advances on the edge leaving T4; a load always wins
  always_comb begin
    r_nxt = r_q;
    if (bus.r_wr) r_nxt = bus.r_wdata;
    else if (st == T4) r_nxt = {r_q[7], r_q[6:0] + 7'd1};
  end

  assign is_op  = nxt_typ == C_OPF;
  assign is_mrd = nxt_typ == C_MRD;
  assign is_mwr = nxt_typ == C_MWR;
  assign is_ird = nxt_typ == C_IRD;
  assign is_iwr = nxt_typ == C_IWR;
  assign busy   = nxt inside {T1, T2, TA, TW, T3};
  assign fin_n  = (nxt == T4) || ((nxt == T3) && !is_op);

  // Outputs decoded from the next state, so they come straight off flops
  always_comb begin
    m1_n   = 1'b1;
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    rfsh_n = 1'b1;
    a_n    = addr_q;
    d_n    = dout_q;
    unique case (1'b1)
      is_op: begin
        if (nxt inside {T1, T2, TW}) begin
          m1_n   = 1'b0;
          mreq_n = 1'b0;
          rd_n   = 1'b0;
          a_n    = nxt_addr;
        end else if (nxt inside {T3, T4}) begin
          mreq_n = 1'b0;
          rfsh_n = 1'b0;
          a_n    = {bus.i_reg, r_nxt};
        end
      end
      is_mrd: if (busy) begin
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        a_n    = nxt_addr;
      end
      is_mwr: if (busy) begin
        mreq_n = 1'b0;
        wr_n   = (nxt == T1);
        a_n    = nxt_addr;
        d_n    = nxt_wd;
      end
      is_ird: if (busy) begin
        iorq_n = (nxt == T1);
        rd_n   = (nxt == T1);
        a_n    = nxt_addr;
      end
      is_iwr: if (busy) begin
        iorq_n = (nxt == T1);
        wr_n   = (nxt == T1);
        a_n    = nxt_addr;
        d_n    = nxt_wd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      typ      <= C_OPF;
      cap_addr <= '0;
      cap_wd   <= '0;
      ta_cnt   <= '0;
      r_q      <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      m1_q     <= 1'b1;
      mreq_q   <= 1'b1;
      iorq_q   <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      rfsh_q   <= 1'b1;
      addr_q   <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
    end else begin
      st       <= nxt;
      typ      <= nxt_typ;
      cap_addr <= nxt_addr;
      cap_wd   <= nxt_wd;
      ta_cnt   <= (st == TA) ? ta_cnt + 2'd1 : 2'd0;
      r_q      <= r_nxt;
      ready_q  <= (nxt == IDLE) || fin_n;
      done_q   <= fin_n;
      m1_q     <= m1_n;
      mreq_q   <= mreq_n;
      iorq_q   <= iorq_n;
      rd_q     <= rd_n;
      wr_q     <= wr_n;
      rfsh_q   <= rfsh_n;
      addr_q   <= a_n;
      dout_q   <= d_n;
      // Opcode is taken as T3 begins; other reads at the end of T3
      if ((typ == C_OPF && (st == T2 || st == TW) && nxt == T3) ||
          ((typ == C_MRD || typ == C_IRD) && st == T3))
        rdata_q <= bus.data_in;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.M1_L     = m1_q;
  assign bus.MREQ_L   = mreq_q;
  assign bus.IORQ_L   = iorq_q;
  assign bus.RD_L     = rd_q;
  assign bus.WR_L     = wr_q;
  assign bus.RFSH_L   = rfsh_q;
  assign bus.addr_out = addr_q;
  assign bus.data_out = dout_q;
  assign bus.rdata    = rdata_q;
  assign bus.r_reg    = r_q;
endmodule
